// File: rtl/fpu_norm_pkg.sv
// Shared types and defaults for the FPU add/sub mantissa normalizer.
package fpu_norm_pkg;

  localparam int NORM_EW = 8;
  localparam int NORM_MW = 32;
  localparam int EXP_MAX = (2 ** NORM_EW) - 1;

  typedef struct packed {
    logic               sign;
    logic [NORM_EW-1:0] exp;
    logic [NORM_MW-1:0] man;
  } fp_raw_t;

  typedef enum logic [1:0] {
    NC_ZERO   = 2'd0,
    NC_CARRY  = 2'd1,
    NC_LEFT   = 2'd2,
    NC_DENORM = 2'd3
  } norm_case_e;

  // Priority order matters: a zero mantissa wins over a carry, a carry over a left shift.
  function automatic norm_case_e classify_case(input logic zero, input logic carry,
                                               input logic lz_lt_exp);
    norm_case_e c;
    if (zero) begin
      c = NC_ZERO;
    end else if (carry) begin
      c = NC_CARRY;
    end else if (lz_lt_exp) begin
      c = NC_LEFT;
    end else begin
      c = NC_DENORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/Barrel_Shifter.sv
// ALU barrel shifter: Alu_cntrl 2'b00 shifts A left by B, 2'b01 shifts right.
module Barrel_Shifter (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  Alu_cntrl,
  output logic [31:0] Y
);

  // Shift amounts of 32 or more flush the word to zero.
  always_comb begin
    case (Alu_cntrl)
      2'b00:   Y = A << B;
      2'b01:   Y = A >> B;
      default: Y = A;
    endcase
  end

endmodule

// File: rtl/lzc_count.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module lzc_count #(
  parameter int WIDTH = 31
) (
  input  logic [WIDTH-1:0]       din,
  output logic [$clog2(WIDTH):0] cnt
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Scan upward so the highest set bit makes the final assignment.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) begin
        cnt = CW'(WIDTH - 1 - i);
      end else begin
        cnt = cnt;
      end
    end
  end

endmodule

// File: rtl/fp_mantissa_normalizer.sv
// Two-stage normalizer upstream of rounding: stage 1 counts leading zeros,
// stage 2 shifts the mantissa, adjusts the exponent and flags zero/overflow/underflow.
module fp_mantissa_normalizer
  import fpu_norm_pkg::*;
#(
  parameter int EW = NORM_EW,
  parameter int MW = NORM_MW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [MW-1:0] in_man,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [MW-2:0] out_man,
  output logic          out_sticky,
  output logic          out_zero,
  output logic          out_oflow,
  output logic          out_uflow
);

  localparam int          LZW       = $clog2(MW - 1) + 1;
  localparam logic [EW:0] EXP_MAX_X = (EW + 1)'((2 ** EW) - 1);

  logic           adv1_s, adv2_s;
  logic           s1_valid_r, s1_sign_r, s1_carry_r, s1_zero_r;
  logic [EW-1:0]  s1_exp_r;
  logic [MW-1:0]  s1_man_r;
  logic [LZW-1:0] s1_lz_r;
  logic [LZW-1:0] lz_s;

  assign adv2_s   = !out_valid || out_ready;
  assign adv1_s   = !s1_valid_r || adv2_s;
  assign in_ready = adv1_s;

  lzc_count #(.WIDTH(MW - 1)) u_lzc (
    .din (in_man[MW-2:0]),
    .cnt (lz_s)
  );

  // Stage 1: capture the beat with its carry, zero and leading-zero summary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_exp_r   <= '0;
      s1_man_r   <= '0;
      s1_carry_r <= 1'b0;
      s1_zero_r  <= 1'b0;
      s1_lz_r    <= '0;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sign_r  <= in_sign;
        s1_exp_r   <= in_exp;
        s1_man_r   <= in_man;
        s1_carry_r <= in_man[MW-1];
        s1_zero_r  <= (in_man == '0);
        s1_lz_r    <= lz_s;
      end
    end
  end

  logic [EW:0]   exp_x_s, lz_x_s, exp_p1_s, exp_mlz_s, exp_m1_s, amt_s;
  logic [1:0]    dir_s;
  logic [MW-1:0] shift_b_s, shift_y_s;
  logic          shift_unused_s;
  norm_case_e    case_s;
  logic [EW-1:0] n_exp_s;
  logic [MW-2:0] n_man_s;
  logic          n_sticky_s, n_zero_s, n_oflow_s, n_uflow_s;

  assign exp_x_s   = {1'b0, s1_exp_r};
  assign lz_x_s    = (EW + 1)'(s1_lz_r);
  assign exp_p1_s  = exp_x_s + (EW + 1)'(1);
  assign exp_mlz_s = exp_x_s - lz_x_s;
  assign exp_m1_s  = exp_x_s - (EW + 1)'(1);
  assign case_s    = classify_case(s1_zero_r, s1_carry_r, lz_x_s < exp_x_s);
  assign shift_b_s = MW'(amt_s);

  Barrel_Shifter u_shift (
    .A         (s1_man_r),
    .B         (shift_b_s),
    .Alu_cntrl (dir_s),
    .Y         (shift_y_s)
  );

  // The carry position is always clear after normalization.
  assign shift_unused_s = shift_y_s[MW-1];

  // Stage 2 datapath: pick the case, steer the shifter and form the result.
  always_comb begin
    dir_s      = 2'b00;
    amt_s      = '0;
    n_exp_s    = '0;
    n_man_s    = '0;
    n_sticky_s = 1'b0;
    n_zero_s   = 1'b0;
    n_oflow_s  = 1'b0;
    n_uflow_s  = 1'b0;
    case (case_s)
      NC_ZERO: begin
        n_zero_s = 1'b1;
      end
      NC_CARRY: begin
        dir_s      = 2'b01;
        amt_s      = (EW + 1)'(1);
        n_sticky_s = s1_man_r[0];
        if (exp_p1_s >= EXP_MAX_X) begin
          n_exp_s   = EXP_MAX_X[EW-1:0];
          n_oflow_s = 1'b1;
        end else begin
          n_exp_s = exp_p1_s[EW-1:0];
          n_man_s = shift_y_s[MW-2:0];
        end
      end
      NC_LEFT: begin
        // An already-saturated exponent passes through as overflow.
        if (exp_x_s == EXP_MAX_X) begin
          n_exp_s   = EXP_MAX_X[EW-1:0];
          n_oflow_s = 1'b1;
        end else begin
          amt_s   = lz_x_s;
          n_exp_s = exp_mlz_s[EW-1:0];
          n_man_s = shift_y_s[MW-2:0];
        end
      end
      NC_DENORM: begin
        n_uflow_s = 1'b1;
        if (s1_exp_r == '0) begin
          amt_s = '0;
        end else begin
          amt_s = exp_m1_s;
        end
        n_man_s = shift_y_s[MW-2:0];
      end
      default: begin
        n_zero_s = 1'b0;
      end
    endcase
  end

  // Stage 2 output registers; held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_exp    <= '0;
      out_man    <= '0;
      out_sticky <= 1'b0;
      out_zero   <= 1'b0;
      out_oflow  <= 1'b0;
      out_uflow  <= 1'b0;
    end else if (adv2_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_sign   <= s1_sign_r;
        out_exp    <= n_exp_s;
        out_man    <= n_man_s;
        out_sticky <= n_sticky_s;
        out_zero   <= n_zero_s;
        out_oflow  <= n_oflow_s;
        out_uflow  <= n_uflow_s;
      end
    end
  end

endmodule

// File: tb/tb_fp_mantissa_normalizer.sv
// Scoreboard bench for fp_mantissa_normalizer: a reference model queues the expected
// result of every accepted beat, and the output monitor pops and compares in order.
module tb_fp_mantissa_normalizer;
  import fpu_norm_pkg::*;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [30:0] man;
    logic        sticky;
    logic        zero;
    logic        oflow;
    logic        uflow;
  } exp_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [31:0] in_man;
  logic        out_valid, out_ready, out_sign;
  logic [7:0]  out_exp;
  logic [30:0] out_man;
  logic        out_sticky, out_zero, out_oflow, out_uflow;

  fp_mantissa_normalizer #(.EW(8), .MW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_man     (in_man),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_exp    (out_exp),
    .out_man    (out_man),
    .out_sticky (out_sticky),
    .out_zero   (out_zero),
    .out_oflow  (out_oflow),
    .out_uflow  (out_uflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_acc    = 0;
  bit   rnd_done = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic fp_raw_t mk(input logic s, input int e, input logic [31:0] m);
    fp_raw_t b;
    b.sign = s;
    b.exp  = 8'(e);
    b.man  = m;
    return b;
  endfunction

  // Reference behaviour of the normalizer for one input beat.
  function automatic exp_t model(input fp_raw_t b);
    exp_t        r;
    int          e, p, lz, sh;
    logic [31:0] shifted;
    r      = '0;
    r.sign = b.sign;
    e      = int'(b.exp);
    if (b.man == 32'd0) begin
      r.zero = 1'b1;
    end else if (b.man[31]) begin
      r.sticky = b.man[0];
      if (e + 1 >= 255) begin
        r.exp   = 8'd255;
        r.oflow = 1'b1;
      end else begin
        r.exp = 8'(e + 1);
        r.man = b.man[31:1];
      end
    end else if (e == 255) begin
      r.exp   = 8'd255;
      r.oflow = 1'b1;
    end else begin
      p = -1;
      for (int i = 0; i < 31; i++) begin
        if (b.man[i]) p = i;
      end
      lz = 30 - p;
      if (lz < e) begin
        shifted = b.man << lz;
        r.exp   = 8'(e - lz);
      end else begin
        sh      = (e == 0) ? 0 : e - 1;
        shifted = b.man << sh;
        r.uflow = 1'b1;
      end
      r.man = shifted[30:0];
    end
    return r;
  endfunction

  task automatic send(input fp_raw_t b);
    bit done_b;
    done_b   = 1'b0;
    in_valid = 1'b1;
    in_sign  = b.sign;
    in_exp   = b.exp;
    in_man   = b.man;
    for (int k = 0; k < 64 && !done_b; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(b));
        n_acc++;
        done_b = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done_b) check_val("send_timeout", 64'(done_b), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: each transfer is compared against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("sign",   64'(out_sign),   64'(mon_e.sign));
        check_val("exp",    64'(out_exp),    64'(mon_e.exp));
        check_val("man",    64'(out_man),    64'(mon_e.man));
        check_val("sticky", 64'(out_sticky), 64'(mon_e.sticky));
        check_val("zero",   64'(out_zero),   64'(mon_e.zero));
        check_val("oflow",  64'(out_oflow),  64'(mon_e.oflow));
        check_val("uflow",  64'(out_uflow),  64'(mon_e.uflow));
      end
    end
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_man    = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_exp",   64'(out_exp),   64'd0);
    check_val("rst_out_man",   64'(out_man),   64'd0);
    check_val("rst_flags",     64'({out_sticky, out_zero, out_oflow, out_uflow}), 64'd0);
    check_val("rst_in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, first one also checks the two-cycle latency.
    send(mk(1'b0, 100, 32'h4000_0000));
    check_val("lat_cycle1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check_val("lat_cycle2", 64'(out_valid), 64'd1);
    send(mk(1'b1, 100, 32'h8000_0001));
    send(mk(1'b0, 100, 32'h0000_1000));
    send(mk(1'b0, 5,   32'h0000_1000));
    send(mk(1'b1, 77,  32'h0000_0000));
    send(mk(1'b0, 254, 32'h8000_0000));
    send(mk(1'b0, 253, 32'h8000_0003));
    send(mk(1'b0, 255, 32'h4000_0000));
    send(mk(1'b0, 0,   32'h0000_1000));
    send(mk(1'b1, 31,  32'h0000_0001));
    send(mk(1'b0, 30,  32'h0000_0001));
    drain();

    // Backpressure: two beats fill the pipe, the third waits for out_ready.
    out_ready = 1'b0;
    base = n_acc;
    send(mk(1'b0, 100, 32'h4000_0000));
    send(mk(1'b1, 120, 32'h0000_00ff));
    fork
      send(mk(1'b0, 90, 32'h8000_0000));
      begin
        @(negedge clk);
        check_val("bp_in_ready_low", 64'(in_ready), 64'd0);
        check_val("bp_accepted", 64'(n_acc - base), 64'd2);
        repeat (3) begin
          @(negedge clk);
          check_val("bp_hold_valid", 64'(out_valid), 64'd1);
          check_val("bp_hold_exp",   64'(out_exp),   64'(exp_q[0].exp));
          check_val("bp_hold_man",   64'(out_man),   64'(exp_q[0].man));
          check_val("bp_hold_ready", 64'(in_ready),  64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random beats under random downstream stalls.
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                  32'($urandom) >> $urandom_range(0, 32)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight: both must vanish.
    send(mk(1'b0, 60, 32'h0001_0000));
    send(mk(1'b1, 61, 32'h0002_0000));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 64'(out_valid), 64'd0);
    check_val("midrst_in_ready",  64'(in_ready),  64'd1);
    check_val("midrst_out_man",   64'(out_man),   64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_val("post_rst_idle", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(mk(1'b0, 40, 32'h0000_0100));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
